// File: rtl/conv3x3_pe_scheduler.sv
// Sequencer for the 3x3 multiplier-array PE over one output channel of a valid convolution.
// Output positions are walked row-major. For each position, one window is requested per input
// channel, the 9 PE products of each window are summed, and the sums are accumulated across
// channels. One result per position is presented on a valid/ready port.
module conv3x3_pe_scheduler #(
   parameter int unsigned DIM_W  = 8,
   parameter int unsigned CH_W   = 10,
   parameter int unsigned PROD_W = 25,
   parameter int unsigned ACC_W  = PROD_W + 4 + CH_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [DIM_W-1:0]         cfg_w,
   input  logic [DIM_W-1:0]         cfg_h,
   input  logic [CH_W-1:0]          cfg_cin,
   output logic                     busy,
   output logic                     done,
   output logic                     win_req,
   output logic [DIM_W-1:0]         win_row,
   output logic [DIM_W-1:0]         win_col,
   output logic [CH_W-1:0]          win_ch,
   input  logic                     win_ack,
   input  logic [9*PROD_W-1:0]      prod_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  out_data,
   output logic [DIM_W-1:0]         out_row,
   output logic [DIM_W-1:0]         out_col
);

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StOut,
      StDone
   } state_e;

   state_e                   state_q, state_d;
   logic [DIM_W-1:0]         cfg_w_q, cfg_w_d;
   logic [DIM_W-1:0]         cfg_h_q, cfg_h_d;
   logic [CH_W-1:0]          cfg_cin_q, cfg_cin_d;
   logic [DIM_W-1:0]         row_q, row_d;
   logic [DIM_W-1:0]         col_q, col_d;
   logic [CH_W-1:0]          ch_q, ch_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;

   logic signed [ACC_W-1:0]  win_sum;
   logic [PROD_W-1:0]        prod_k;
   logic [DIM_W-1:0]         last_col;
   logic [DIM_W-1:0]         last_row;
   logic                     cfg_too_small;

   // Last valid top-left coordinates of a 3x3 window inside the latched map.
   assign last_col = cfg_w_q - DIM_W'(3);
   assign last_row = cfg_h_q - DIM_W'(3);

   // A map narrower/shorter than the kernel, or zero channels, yields no outputs at all.
   assign cfg_too_small = (cfg_w < DIM_W'(3)) || (cfg_h < DIM_W'(3)) || (cfg_cin == '0);

   // Sign-extended sum of the nine PE products of the current window.
   always_comb begin
      win_sum = '0;
      prod_k  = '0;
      for (int i = 0; i < 9; i++) begin
         prod_k  = prod_in[i*PROD_W +: PROD_W];
         win_sum = win_sum + {{(ACC_W-PROD_W){prod_k[PROD_W-1]}}, prod_k};
      end
   end

   // Next-state logic for the FSM, position/channel counters and accumulator.
   always_comb begin
      state_d   = state_q;
      cfg_w_d   = cfg_w_q;
      cfg_h_d   = cfg_h_q;
      cfg_cin_d = cfg_cin_q;
      row_d     = row_q;
      col_d     = col_q;
      ch_d      = ch_q;
      acc_d     = acc_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               cfg_w_d   = cfg_w;
               cfg_h_d   = cfg_h;
               cfg_cin_d = cfg_cin;
               row_d     = '0;
               col_d     = '0;
               ch_d      = '0;
               state_d   = cfg_too_small ? StDone : StReq;
            end
         end

         StReq: begin
            if (win_ack) begin
               // Channel 0 restarts the accumulation for a new output position.
               acc_d = (ch_q == '0) ? win_sum : acc_q + win_sum;
               if (ch_q < cfg_cin_q - CH_W'(1)) begin
                  ch_d = ch_q + CH_W'(1);
               end else begin
                  state_d = StOut;
               end
            end
         end

         StOut: begin
            if (out_ready) begin
               ch_d = '0;
               if (col_q == last_col) begin
                  col_d = '0;
                  row_d = row_q + DIM_W'(1);
               end else begin
                  col_d = col_q + DIM_W'(1);
               end
               state_d = ((row_q == last_row) && (col_q == last_col)) ? StDone : StReq;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers; reset clears everything so all outputs read zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cfg_w_q   <= '0;
         cfg_h_q   <= '0;
         cfg_cin_q <= '0;
         row_q     <= '0;
         col_q     <= '0;
         ch_q      <= '0;
         acc_q     <= '0;
      end else begin
         state_q   <= state_d;
         cfg_w_q   <= cfg_w_d;
         cfg_h_q   <= cfg_h_d;
         cfg_cin_q <= cfg_cin_d;
         row_q     <= row_d;
         col_q     <= col_d;
         ch_q      <= ch_d;
         acc_q     <= acc_d;
      end
   end

   // Outputs decode directly from state and registers, so they stay stable while stalled.
   always_comb begin
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
      win_req   = (state_q == StReq);
      win_row   = row_q;
      win_col   = col_q;
      win_ch    = ch_q;
      out_valid = (state_q == StOut);
      out_data  = acc_q;
      out_row   = row_q;
      out_col   = col_q;
   end

endmodule
